// File: rtl/id_stage_fwd_pkg.sv
// Shared RV32I decode definitions: opcode/funct constants, immediate formats,
// and the per-instruction control decode used by the registered ID stage.
package id_stage_fwd_pkg;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;
  localparam logic [6:0]  NON_OP   = 7'b000_0000;

  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;

  localparam logic [2:0] F3_JALR    = 3'b000;
  localparam logic [2:0] F3_BEQ     = 3'b000;
  localparam logic [2:0] F3_BNE     = 3'b001;
  localparam logic [2:0] F3_BLT     = 3'b100;
  localparam logic [2:0] F3_BGE     = 3'b101;
  localparam logic [2:0] F3_BLTU    = 3'b110;
  localparam logic [2:0] F3_BGEU    = 3'b111;
  localparam logic [2:0] F3_LB      = 3'b000;
  localparam logic [2:0] F3_LH      = 3'b001;
  localparam logic [2:0] F3_LW      = 3'b010;
  localparam logic [2:0] F3_LBU     = 3'b100;
  localparam logic [2:0] F3_LHU     = 3'b101;
  localparam logic [2:0] F3_SB      = 3'b000;
  localparam logic [2:0] F3_SH      = 3'b001;
  localparam logic [2:0] F3_SW      = 3'b010;
  localparam logic [2:0] F3_ADD_SUB = 3'b000;
  localparam logic [2:0] F3_SLL     = 3'b001;
  localparam logic [2:0] F3_SRL_SRA = 3'b101;

  localparam logic [6:0] F7_BASE = 7'b000_0000;
  localparam logic [6:0] F7_ALT  = 7'b010_0000;

  typedef enum logic [2:0] {
    IMM_NONE,
    IMM_I,
    IMM_S,
    IMM_B,
    IMM_U,
    IMM_J
  } imm_fmt_e;

  // Everything the stage needs to know about an instruction besides its raw fields.
  typedef struct packed {
    logic     legal;
    imm_fmt_e fmt;
    logic     rs1_used;
    logic     rs2_used;
    logic     writes;
    logic     keep_f3;
    logic     keep_f7;
  } dec_ctrl_t;

  function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_fmt_e fmt);
    logic [31:0] imm;
    imm = ZeroWord;
    case (fmt)
      IMM_I: imm = {{20{inst[31]}}, inst[31:20]};
      IMM_S: imm = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      IMM_B: imm = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      IMM_U: imm = {inst[31:12], 12'b0};
      IMM_J: imm = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      default: imm = ZeroWord;
    endcase
    return imm;
  endfunction

  // An illegal encoding collapses to an all-zero control word: no operands,
  // no write, no immediate, so it can never cause a load-use stall.
  function automatic dec_ctrl_t decode_ctrl(input logic [31:0] inst);
    dec_ctrl_t   c;
    logic [2:0]  f3;
    logic [6:0]  f7;
    f3 = inst[14:12];
    f7 = inst[31:25];
    c  = '0;
    case (inst[6:0])
      OPC_LUI, OPC_AUIPC: begin
        c.legal  = 1'b1;
        c.fmt    = IMM_U;
        c.writes = 1'b1;
      end
      OPC_JAL: begin
        c.legal  = 1'b1;
        c.fmt    = IMM_J;
        c.writes = 1'b1;
      end
      OPC_JALR: begin
        c.legal    = (f3 == F3_JALR);
        c.fmt      = IMM_I;
        c.rs1_used = 1'b1;
        c.writes   = 1'b1;
        c.keep_f3  = 1'b1;
      end
      OPC_BRANCH: begin
        c.legal    = f3 inside {F3_BEQ, F3_BNE, F3_BLT, F3_BGE, F3_BLTU, F3_BGEU};
        c.fmt      = IMM_B;
        c.rs1_used = 1'b1;
        c.rs2_used = 1'b1;
        c.keep_f3  = 1'b1;
      end
      OPC_LOAD: begin
        c.legal    = f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
        c.fmt      = IMM_I;
        c.rs1_used = 1'b1;
        c.writes   = 1'b1;
        c.keep_f3  = 1'b1;
      end
      OPC_STORE: begin
        c.legal    = f3 inside {F3_SB, F3_SH, F3_SW};
        c.fmt      = IMM_S;
        c.rs1_used = 1'b1;
        c.rs2_used = 1'b1;
        c.keep_f3  = 1'b1;
      end
      OPC_OP_IMM: begin
        if (f3 == F3_SLL)          c.legal = (f7 == F7_BASE);
        else if (f3 == F3_SRL_SRA) c.legal = f7 inside {F7_BASE, F7_ALT};
        else                       c.legal = 1'b1;
        c.fmt      = IMM_I;
        c.rs1_used = 1'b1;
        c.writes   = 1'b1;
        c.keep_f3  = 1'b1;
        c.keep_f7  = (f3 == F3_SLL) || (f3 == F3_SRL_SRA);
      end
      OPC_OP: begin
        c.legal    = (f7 == F7_BASE) ||
                     ((f7 == F7_ALT) && ((f3 == F3_ADD_SUB) || (f3 == F3_SRL_SRA)));
        c.rs1_used = 1'b1;
        c.rs2_used = 1'b1;
        c.writes   = 1'b1;
        c.keep_f3  = 1'b1;
        c.keep_f7  = 1'b1;
      end
      default: c = '0;
    endcase
    if (!c.legal) c = '0;
    return c;
  endfunction

endpackage

// File: rtl/id_stage_fwd_fwd_mux.sv
// Operand resolver: x0 reads as zero, otherwise the youngest matching
// forwarding source wins, otherwise the regfile value is used.
module id_fwd_mux
  import id_stage_fwd_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int FWD_PORTS = 2
) (
  input  logic [REG_AW-1:0]           addr,
  input  logic [XLEN-1:0]             rf_data,
  input  logic [FWD_PORTS-1:0]        fwd_we,
  input  logic [FWD_PORTS*REG_AW-1:0] fwd_addr,
  input  logic [FWD_PORTS*XLEN-1:0]   fwd_data,
  output logic [XLEN-1:0]             operand
);

  // NOTE: operand gets a value before any conditional update so this always_comb
  // can never infer a latch when no source matches.
  always_comb begin
    operand = rf_data;
    // Walk oldest to youngest so the lowest matching index is the last write.
    for (int k = FWD_PORTS - 1; k >= 0; k--) begin
      if (fwd_we[k] && (fwd_addr[k*REG_AW +: REG_AW] == addr)) begin
        operand = fwd_data[k*XLEN +: XLEN];
      end
    end
    if (addr == '0) operand = ZeroWord;
  end

endmodule

// File: rtl/id_stage_fwd.sv
// Registered RV32I decode stage: full decode, operand forwarding, load-use
// stall, flush, and a valid/ready output register between if_id and ex.
module id_stage_fwd
  import id_stage_fwd_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int REG_AW    = 5,
  parameter int FWD_PORTS = 2
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          flush,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic [XLEN-1:0]               pc_i,
  input  logic [31:0]                   inst_i,
  output logic [REG_AW-1:0]             reg1_addr_o,
  output logic [REG_AW-1:0]             reg2_addr_o,
  input  logic [XLEN-1:0]               reg1_data_i,
  input  logic [XLEN-1:0]               reg2_data_i,
  input  logic [FWD_PORTS-1:0]          fwd_we,
  input  logic [FWD_PORTS*REG_AW-1:0]   fwd_addr,
  input  logic [FWD_PORTS*XLEN-1:0]     fwd_data,
  input  logic                          ex_is_load,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [6:0]                    opcode_o,
  output logic [2:0]                    funct3_o,
  output logic [6:0]                    funct7_o,
  output logic [XLEN-1:0]               op1_o,
  output logic [XLEN-1:0]               op2_o,
  output logic [XLEN-1:0]               imm_o,
  output logic [XLEN-1:0]               pc_o,
  output logic [REG_AW-1:0]             wd_o,
  output logic                          wreg_o,
  output logic                          illegal_o
);

  dec_ctrl_t         ctrl;
  logic [XLEN-1:0]   rs1_val;
  logic [XLEN-1:0]   rs2_val;
  logic [REG_AW-1:0] ex_addr;
  logic [REG_AW-1:0] rd;
  logic              stall;
  logic              accept;

  logic [6:0]        opcode_n;
  logic [2:0]        funct3_n;
  logic [6:0]        funct7_n;
  logic [XLEN-1:0]   op1_n;
  logic [XLEN-1:0]   op2_n;
  logic [XLEN-1:0]   imm_n;
  logic [REG_AW-1:0] wd_n;
  logic              wreg_n;

  assign ctrl        = decode_ctrl(inst_i);
  assign reg1_addr_o = inst_i[19:15];
  assign reg2_addr_o = inst_i[24:20];
  assign rd          = inst_i[11:7];

  id_fwd_mux #(
    .XLEN      (XLEN),
    .REG_AW    (REG_AW),
    .FWD_PORTS (FWD_PORTS)
  ) u_fwd_rs1 (
    .addr     (reg1_addr_o),
    .rf_data  (reg1_data_i),
    .fwd_we   (fwd_we),
    .fwd_addr (fwd_addr),
    .fwd_data (fwd_data),
    .operand  (rs1_val)
  );

  id_fwd_mux #(
    .XLEN      (XLEN),
    .REG_AW    (REG_AW),
    .FWD_PORTS (FWD_PORTS)
  ) u_fwd_rs2 (
    .addr     (reg2_addr_o),
    .rf_data  (reg2_data_i),
    .fwd_we   (fwd_we),
    .fwd_addr (fwd_addr),
    .fwd_data (fwd_data),
    .operand  (rs2_val)
  );

  // Source 0 is ex; a load there has no data yet, so a dependent op must wait.
  assign ex_addr = fwd_addr[REG_AW-1:0];
  assign stall   = ex_is_load && fwd_we[0] && (ex_addr != '0) &&
                   ((ctrl.rs1_used && (ex_addr == reg1_addr_o)) ||
                    (ctrl.rs2_used && (ex_addr == reg2_addr_o)));

  assign in_ready = !rst && !stall && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready && !flush;

  assign opcode_n = ctrl.legal   ? inst_i[6:0]   : NON_OP;
  assign funct3_n = ctrl.keep_f3 ? inst_i[14:12] : 3'b000;
  assign funct7_n = ctrl.keep_f7 ? inst_i[31:25] : 7'b000_0000;
  assign op1_n    = ctrl.rs1_used ? rs1_val : ZeroWord;
  assign op2_n    = ctrl.rs2_used ? rs2_val : ZeroWord;
  assign imm_n    = gen_imm(inst_i, ctrl.fmt);
  assign wd_n     = ctrl.writes ? rd : '0;
  assign wreg_n   = ctrl.writes && (rd != '0);

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid <= 1'b0;
      opcode_o  <= NON_OP;
      funct3_o  <= 3'b000;
      funct7_o  <= 7'b000_0000;
      op1_o     <= ZeroWord;
      op2_o     <= ZeroWord;
      imm_o     <= ZeroWord;
      pc_o      <= ZeroWord;
      wd_o      <= '0;
      wreg_o    <= 1'b0;
      illegal_o <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (accept) begin
      out_valid <= 1'b1;
      opcode_o  <= opcode_n;
      funct3_o  <= funct3_n;
      funct7_o  <= funct7_n;
      op1_o     <= op1_n;
      op2_o     <= op2_n;
      imm_o     <= imm_n;
      pc_o      <= pc_i;
      wd_o      <= wd_n;
      wreg_o    <= wreg_n;
      illegal_o <= !ctrl.legal;
    end else if (out_ready) begin
      // Consumed with nothing new behind it (including a stall): emit a bubble.
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_id_stage_fwd.sv
// Self-checking bench for id_stage_fwd: directed scenarios followed by random
// traffic, all compared against a behavioural model of the decode stage.
module tb_id_stage_fwd;

  localparam int FWD = 2;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] pc_i;
  logic [31:0] inst_i;
  logic [4:0]  reg1_addr_o;
  logic [4:0]  reg2_addr_o;
  logic [31:0] reg1_data_i;
  logic [31:0] reg2_data_i;
  logic [FWD-1:0]    fwd_we;
  logic [FWD*5-1:0]  fwd_addr;
  logic [FWD*32-1:0] fwd_data;
  logic        ex_is_load;
  logic        out_valid;
  logic        out_ready;
  logic [6:0]  opcode_o;
  logic [2:0]  funct3_o;
  logic [6:0]  funct7_o;
  logic [31:0] op1_o;
  logic [31:0] op2_o;
  logic [31:0] imm_o;
  logic [31:0] pc_o;
  logic [4:0]  wd_o;
  logic        wreg_o;
  logic        illegal_o;

  logic [31:0] rf [32];
  logic [4:0]  fwd_addr_a [FWD];
  logic [31:0] fwd_data_a [FWD];

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        valid;
    logic [6:0]  opcode;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] op1;
    logic [31:0] op2;
    logic [31:0] imm;
    logic [31:0] pc;
    logic [4:0]  wd;
    logic        wreg;
    logic        illegal;
    logic        u1;
    logic        u2;
  } exp_t;

  exp_t m;

  localparam logic [7:0] BR_OK = 8'b1111_0011;
  localparam logic [7:0] LD_OK = 8'b0011_0111;
  localparam logic [7:0] ST_OK = 8'b0000_0111;

  assign reg1_data_i = rf[reg1_addr_o];
  assign reg2_data_i = rf[reg2_addr_o];
  assign fwd_addr    = {fwd_addr_a[1], fwd_addr_a[0]};
  assign fwd_data    = {fwd_data_a[1], fwd_data_a[0]};

  id_stage_fwd #(.XLEN(32), .REG_AW(5), .FWD_PORTS(FWD)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .pc_i        (pc_i),
    .inst_i      (inst_i),
    .reg1_addr_o (reg1_addr_o),
    .reg2_addr_o (reg2_addr_o),
    .reg1_data_i (reg1_data_i),
    .reg2_data_i (reg2_data_i),
    .fwd_we      (fwd_we),
    .fwd_addr    (fwd_addr),
    .fwd_data    (fwd_data),
    .ex_is_load  (ex_is_load),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .opcode_o    (opcode_o),
    .funct3_o    (funct3_o),
    .funct7_o    (funct7_o),
    .op1_o       (op1_o),
    .op2_o       (op2_o),
    .imm_o       (imm_o),
    .pc_o        (pc_o),
    .wd_o        (wd_o),
    .wreg_o      (wreg_o),
    .illegal_o   (illegal_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] sext(input logic [31:0] v, input int bits);
    return v[bits-1] ? v - (32'd1 << bits) : v;
  endfunction

  function automatic logic [31:0] ref_operand(input logic [4:0] a);
    if (a == 5'd0) return 32'd0;
    for (int k = 0; k < FWD; k++) begin
      if (fwd_we[k] && fwd_addr_a[k] == a) return fwd_data_a[k];
    end
    return rf[a];
  endfunction

  function automatic exp_t ref_decode(input logic [31:0] inst, input logic [31:0] pc);
    exp_t        e;
    logic [6:0]  opc;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [4:0]  rd;
    bit          legal, wr, kf3, kf7;
    logic [31:0] imm;
    e     = '{default: 0};
    opc   = inst[6:0];
    f3    = inst[14:12];
    f7    = inst[31:25];
    rd    = inst[11:7];
    legal = 0; wr = 0; kf3 = 0; kf7 = 0;
    imm   = 32'd0;
    case (opc)
      7'h37, 7'h17: begin legal = 1; wr = 1; imm = {inst[31:12], 12'h000}; end
      7'h6F: begin
        legal = 1; wr = 1;
        imm = sext(32'({inst[31], inst[19:12], inst[20], inst[30:21], 1'b0}), 21);
      end
      7'h67: begin
        legal = (f3 == 3'd0); wr = 1; kf3 = 1; e.u1 = 1;
        imm = sext(32'(inst[31:20]), 12);
      end
      7'h63: begin
        legal = BR_OK[f3]; kf3 = 1; e.u1 = 1; e.u2 = 1;
        imm = sext(32'({inst[31], inst[7], inst[30:25], inst[11:8], 1'b0}), 13);
      end
      7'h03: begin
        legal = LD_OK[f3]; wr = 1; kf3 = 1; e.u1 = 1;
        imm = sext(32'(inst[31:20]), 12);
      end
      7'h23: begin
        legal = ST_OK[f3]; kf3 = 1; e.u1 = 1; e.u2 = 1;
        imm = sext(32'({inst[31:25], inst[11:7]}), 12);
      end
      7'h13: begin
        wr = 1; kf3 = 1; e.u1 = 1;
        kf7 = (f3 == 3'd1) || (f3 == 3'd5);
        if (f3 == 3'd1)      legal = (f7 == 7'h00);
        else if (f3 == 3'd5) legal = (f7 == 7'h00) || (f7 == 7'h20);
        else                 legal = 1;
        imm = sext(32'(inst[31:20]), 12);
      end
      7'h33: begin
        wr = 1; kf3 = 1; kf7 = 1; e.u1 = 1; e.u2 = 1;
        legal = (f7 == 7'h00) || (f7 == 7'h20 && (f3 == 3'd0 || f3 == 3'd5));
      end
      default: legal = 0;
    endcase
    if (!legal) begin
      e         = '{default: 0};
      e.illegal = 1'b1;
      e.pc      = pc;
      return e;
    end
    e.opcode = opc;
    e.f3     = kf3 ? f3 : 3'd0;
    e.f7     = kf7 ? f7 : 7'd0;
    e.op1    = e.u1 ? ref_operand(inst[19:15]) : 32'd0;
    e.op2    = e.u2 ? ref_operand(inst[24:20]) : 32'd0;
    e.imm    = imm;
    e.pc     = pc;
    e.wd     = wr ? rd : 5'd0;
    e.wreg   = wr && (rd != 5'd0);
    return e;
  endfunction

  function automatic bit ref_stall(input exp_t d, input logic [31:0] inst);
    return ex_is_load && fwd_we[0] && (fwd_addr_a[0] != 5'd0) &&
           ((d.u1 && fwd_addr_a[0] == inst[19:15]) || (d.u2 && fwd_addr_a[0] == inst[24:20]));
  endfunction

  task automatic check_fields();
    check("opcode_o",  32'(opcode_o),  32'(m.opcode));
    check("funct3_o",  32'(funct3_o),  32'(m.f3));
    check("funct7_o",  32'(funct7_o),  32'(m.f7));
    check("op1_o",     op1_o,          m.op1);
    check("op2_o",     op2_o,          m.op2);
    check("imm_o",     imm_o,          m.imm);
    check("pc_o",      pc_o,           m.pc);
    check("wd_o",      32'(wd_o),      32'(m.wd));
    check("wreg_o",    32'(wreg_o),    32'(m.wreg));
    check("illegal_o", 32'(illegal_o), 32'(m.illegal));
  endtask

  // One clock: check combinational outputs, advance the model across the edge,
  // then check the registered outputs. Called just after a falling edge.
  task automatic step();
    exp_t d;
    logic rdy;
    logic was_rst;
    #1;
    d   = ref_decode(inst_i, pc_i);
    rdy = !rst && !ref_stall(d, inst_i) && (!m.valid || out_ready);
    check("in_ready",  32'(in_ready),    32'(rdy));
    check("reg1_addr", 32'(reg1_addr_o), 32'(inst_i[19:15]));
    check("reg2_addr", 32'(reg2_addr_o), 32'(inst_i[24:20]));
    was_rst = rst;
    @(posedge clk);
    if (rst)                     m = '{default: 0};
    else if (flush)              m.valid = 1'b0;
    else if (in_valid && rdy)    begin m = d; m.valid = 1'b1; end
    else if (out_ready)          m.valid = 1'b0;
    #1;
    check("out_valid", 32'(out_valid), 32'(m.valid));
    if (m.valid || was_rst) check_fields();
    @(negedge clk);
  endtask

  function automatic logic [31:0] rand_inst();
    logic [31:0] w;
    logic [6:0]  opcs [10];
    opcs = '{7'h37, 7'h17, 7'h6F, 7'h67, 7'h63, 7'h03, 7'h23, 7'h13, 7'h33, 7'h7F};
    w        = $urandom;
    w[6:0]   = opcs[$urandom_range(0, 9)];
    w[11:7]  = 5'($urandom_range(0, 7));
    w[19:15] = 5'($urandom_range(0, 7));
    w[24:20] = 5'($urandom_range(0, 7));
    if ($urandom_range(0, 1) == 1) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
    return w;
  endfunction

  task automatic set_fwd(input logic [1:0] we, input logic [4:0] a0, input logic [31:0] d0,
                         input logic [4:0] a1, input logic [31:0] d1);
    fwd_we        = we;
    fwd_addr_a[0] = a0;
    fwd_data_a[0] = d0;
    fwd_addr_a[1] = a1;
    fwd_data_a[1] = d1;
  endtask

  initial begin
    m          = '{default: 0};
    rst        = 1'b1;
    flush      = 1'b0;
    in_valid   = 1'b0;
    out_ready  = 1'b1;
    ex_is_load = 1'b0;
    pc_i       = 32'd0;
    inst_i     = 32'h0000_0013;
    set_fwd(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);
    for (int i = 0; i < 32; i++) rf[i] = $urandom;
    rf[0] = 32'hDEAD_BEEF;  // x0 must still read as zero
    @(negedge clk);

    // Reset state
    step();
    check("rst_in_ready", 32'(in_ready), 32'd0);
    rst = 1'b0;

    // ADDI x1,x0,-5
    in_valid = 1'b1; inst_i = 32'hFFB0_0093; pc_i = 32'h100;
    step();
    check("addi_valid", 32'(out_valid), 32'd1);
    check("addi_op1",   op1_o, 32'd0);
    check("addi_imm",   imm_o, 32'hFFFF_FFFB);
    check("addi_wd",    32'(wd_o), 32'd1);
    check("addi_wreg",  32'(wreg_o), 32'd1);
    check("addi_pc",    pc_o, 32'h100);

    // ADD x3,x1,x2 with forwarding priority
    rf[1] = 32'd7; rf[2] = 32'd9;
    inst_i = 32'h0020_81B3; pc_i = 32'h104;
    set_fwd(2'b11, 5'd1, 32'h11, 5'd2, 32'h33);
    step();
    check("add_fwd0_op1", op1_o, 32'h11);
    check("add_fwd1_op2", op2_o, 32'h33);
    set_fwd(2'b11, 5'd9, 32'h99, 5'd1, 32'h22);
    pc_i = 32'h108;
    step();
    check("add_old_op1", op1_o, 32'h22);
    check("add_rf_op2",  op2_o, 32'd9);
    set_fwd(2'b11, 5'd1, 32'h11, 5'd1, 32'h22);
    pc_i = 32'h10C;
    step();
    check("add_young_wins", op1_o, 32'h11);

    // Load-use: LW x5 in ex, ADD x6,x5,x0 waiting
    inst_i = 32'h0002_8333; pc_i = 32'h110;
    set_fwd(2'b01, 5'd5, 32'h55, 5'd0, 32'd0);
    ex_is_load = 1'b1;
    #1 check("lu_in_ready", 32'(in_ready), 32'd0);
    step();
    check("lu_bubble", 32'(out_valid), 32'd0);
    ex_is_load = 1'b0;
    step();
    check("lu_release_valid", 32'(out_valid), 32'd1);
    check("lu_release_op1",   op1_o, 32'h55);
    set_fwd(2'b00, 5'd0, 32'd0, 5'd0, 32'd0);

    // Backpressure: hold LUI x2,0x12345
    inst_i = 32'h1234_5137; pc_i = 32'h120;
    step();
    out_ready = 1'b0;
    inst_i = 32'hFFB0_0093; pc_i = 32'h124;
    for (int i = 0; i < 3; i++) begin
      step();
      check("hold_imm",      imm_o, 32'h1234_5000);
      check("hold_pc",       pc_o, 32'h120);
      check("hold_in_ready", 32'(in_ready), 32'd0);
    end
    out_ready = 1'b1;
    step();
    check("b2b_1_pc", pc_o, 32'h124);
    pc_i = 32'h128;
    step();
    check("b2b_2_pc", pc_o, 32'h128);

    // Flush drops incoming, then reset while valid
    flush = 1'b1; pc_i = 32'h12C;
    step();
    check("flush_valid", 32'(out_valid), 32'd0);
    flush = 1'b0;
    step();
    out_ready = 1'b0;
    rst = 1'b1;
    step();
    check("rst_valid", 32'(out_valid), 32'd0);
    check("rst_imm",   imm_o, 32'd0);
    rst = 1'b0;
    out_ready = 1'b1;

    // Negative offsets and an illegal opcode
    inst_i = 32'hFE20_8CE3; pc_i = 32'h200; step(); check("beq_imm",   imm_o, 32'hFFFF_FFF8);
    inst_i = 32'hFE20_AE23; pc_i = 32'h204; step(); check("sw_imm",    imm_o, 32'hFFFF_FFFC);
    inst_i = 32'hFFDF_F0EF; pc_i = 32'h208; step(); check("jal_imm",   imm_o, 32'hFFFF_FFFC);
    inst_i = 32'hFFFF_F297; pc_i = 32'h20C; step(); check("auipc_imm", imm_o, 32'hFFFF_F000);
    inst_i = 32'h0000_007F; pc_i = 32'h210; step();
    check("ill_flag", 32'(illegal_o), 32'd1);
    check("ill_wreg", 32'(wreg_o),    32'd0);
    check("ill_op",   32'(opcode_o),  32'd0);

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 3) != 0);
      flush      = ($urandom_range(0, 19) == 0);
      rst        = ($urandom_range(0, 59) == 0);
      ex_is_load = ($urandom_range(0, 2) == 0);
      for (int k = 0; k < FWD; k++) begin
        fwd_we[k]     = 1'($urandom_range(0, 1));
        fwd_addr_a[k] = 5'($urandom_range(0, 7));
        fwd_data_a[k] = $urandom;
      end
      rf[$urandom_range(0, 31)] = $urandom;
      inst_i = rand_inst();
      pc_i   = $urandom & 32'hFFFF_FFFC;
      step();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/id_stage_fwd.md
Name: id_stage_fwd

Overview:
Registered RV32I decode stage that generalises the combinational decoder. It adds the full RV32I opcode set, all immediate formats, forwarding from N later pipeline stages, load-use stall detection, flush, and a valid/ready output register. It sits between if_id and ex, drives the regfile read ports, and presents one decoded, operand-resolved instruction per accepted beat.

Parameters:
XLEN, 32, datapath and operand width
REG_AW, 5, register address width
FWD_PORTS, 2, number of forwarding sources; index 0 = youngest (ex), higher index = older (mem, wb...)

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset, synchronous, active-high
flush  in  1  kill held and incoming instruction (branch redirect)
in_valid  in  1  if_id holds an instruction
in_ready  out  1  stage accepts inst_i this cycle
pc_i  in  XLEN  instruction address
inst_i  in  32  instruction word
reg1_addr_o / reg2_addr_o  out  REG_AW  regfile read addresses = inst_i[19:15] / [24:20], combinational
reg1_data_i / reg2_data_i  in  XLEN  regfile read data, same cycle
fwd_we  in  FWD_PORTS  source k will write its register
fwd_addr  in  FWD_PORTS*REG_AW  destination of source k, packed
fwd_data  in  FWD_PORTS*XLEN  result of source k, packed
ex_is_load  in  1  source 0 is a load whose data is not yet available
out_valid  out  1  output register holds an instruction
out_ready  in  1  ex consumes output this cycle
opcode_o / funct3_o / funct7_o  out  7/3/7  decoded fields, NOP/000/0000000 when no op
op1_o / op2_o  out  XLEN  resolved rs1 / rs2 values (0 when unused)
imm_o  out  XLEN  sign-extended immediate
pc_o  out  XLEN  pc of held instruction
wd_o  out  REG_AW  destination register
wreg_o  out  1  write enable, 0 when rd = x0
illegal_o  out  1  unrecognised opcode/funct combination

Behaviour:
- Reset: out_valid=0; every registered output is 0 except opcode_o=NON_OP. in_ready=0 while rst is high.
- Decoded opcodes: LUI, AUIPC, JAL, JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
- Immediate formats:
  - I: {20{inst[31]}}, inst[31:20]
  - S: sign-extended {inst[31:25], inst[11:7]}
  - B: sign-extended {inst[31], inst[7], inst[30:25], inst[11:8], 0}
  - U: {inst[31:12], 12'b0}
  - J: sign-extended {inst[31], inst[19:12], inst[20], inst[30:21], 0}
- Register usage:
  - rs1 used by JALR, BRANCH, LOAD, STORE, OP_IMM, OP.
  - rs2 used by BRANCH, STORE, OP.
  - An unused operand yields 0.
- Operand resolution, per operand:
  - Address x0 gives 0.
  - Otherwise take the lowest k with fwd_we[k] and fwd_addr[k] equal to the address.
  - Otherwise take regfile data.
- Load-use stall: ex_is_load and fwd_we[0] and fwd_addr[0]≠0 and fwd_addr[0] matches a used rs.
  - During a stall in_ready=0.
  - If out_ready (or !out_valid), the output register loads a bubble (out_valid=0).
- Handshake: in_ready = !stall && (!out_valid || out_ready). The accept condition is in_valid && in_ready && !flush.
  - Accept: register all outputs next edge, out_valid=1.
  - out_valid && out_ready without accept: out_valid=0.
  - !out_ready with out_valid: all outputs hold stable.
- Illegal instructions are accepted with illegal_o=1, wreg_o=0, and opcode_o=NON_OP.
- Flush has priority over accept and stall: out_valid=0 next edge and the incoming instruction is dropped.
- Latency is 1 cycle from accept to out_valid. Sustained throughput is 1 instruction per cycle when out_ready is held high.

Decomposition:
- Opcode and funct constants, NON_OP, the immediate-format enum and the ZeroWord localparam go in the shared defines package.
- One sub-module, id_fwd_mux (parametrised by XLEN, REG_AW, FWD_PORTS), is instantiated twice, once per operand.

Test Plan:
- ADDI x1,x0,-5 (0xFFB00093), pc=0x100, out_ready=1 -> next cycle out_valid=1, op1_o=0, imm_o=0xFFFFFFFB, wd_o=1, wreg_o=1, pc_o=0x100.
- ADD x3,x1,x2 with regfile x1=7, fwd[0] x1=0x11, fwd[1] x1=0x22, fwd[1] x2=0x33 -> op1_o=0x11, op2_o=0x33.
- LW x5 in ex (ex_is_load=1, fwd_addr[0]=5) with ADD x6,x5,x0 at input -> in_ready=0 for one cycle, bubble out_valid=0. Release with ex_is_load=0 -> forwarded value, accepted next cycle.
- out_ready=0 for 3 cycles with a LUI x2,0x12345 held -> imm_o=0x12345000 stable, in_ready=0, no new accept. Release -> back-to-back accepts.
- flush=1 together with in_valid=1 -> out_valid=0 next cycle. Assert rst while out_valid=1 -> all outputs reset next edge.
- Encode BEQ, SW, JAL, AUIPC with negative offsets (e.g. JAL -4 -> imm_o=0xFFFFFFFC), plus opcode 0x7F -> illegal_o=1, wreg_o=0.
